// File: rtl/nrisc_arb_pkg.sv
// Shared constants, state encoding and rotation helper for the nRISC memory arbiter.
package nrisc_arb_pkg;

    localparam int NREQ  = 3;
    localparam int CNT_W = 2;

    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_DATA  = 2'd1;
    localparam logic [1:0] REQ_EXT   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // (ptr + step) mod NREQ for step in 0..3
    function automatic logic [1:0] rr_slot(input logic [1:0] ptr, input logic [1:0] step);
        logic [2:0] s;
        s = {1'b0, ptr} + {1'b0, step};
        if (s >= 3'(NREQ)) begin
            s = s - 3'(NREQ);
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/nrisc_rr_pick.sv
// Combinational 3-way rotating-priority picker: first set req after rr_ptr wins.
module nrisc_rr_pick
    import nrisc_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      rr_ptr,
    output logic            gnt_valid,
    output logic [1:0]      gnt_idx
);

    logic [1:0] slot;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = REQ_FETCH;
        slot      = 2'd0;
        // Lowest priority first so the nearest set bit after rr_ptr overwrites the rest.
        for (int k = NREQ; k >= 1; k--) begin
            slot = rr_slot(rr_ptr, 2'(k));
            if (req[slot]) begin
                gnt_valid = 1'b1;
                gnt_idx   = slot;
            end
        end
    end

endmodule

// File: rtl/nrisc_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch, data and DMA/debug.
// Define NRISC_ARB_LOCK_EN to enable the requester-2 locked mode for atomic read-modify-write.
//
// state | meaning
// IDLE  | nothing in flight, arbitrate pending requests
// ISSUE | one-cycle mem_en strobe for the granted access
// WAIT  | counting down the memory read latency
// RESP  | ack pulse to the grantee, read data presented
module nrisc_mem_arbiter
    import nrisc_arb_pkg::*;
#(
    parameter int TAM     = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     we,
    input  logic                lock,
    input  logic [NREQ*TAM-1:0] addr,
    input  logic [NREQ*TAM-1:0] wdata,
    output logic [NREQ-1:0]     ack,
    output logic [TAM-1:0]      rdata,
    output logic                busy,
    output logic                mem_en,
    output logic                mem_we,
    output logic [TAM-1:0]      mem_addr,
    output logic [TAM-1:0]      mem_wdata,
    input  logic [TAM-1:0]      mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_lat_check
        $error("nrisc_mem_arbiter: MEM_LAT must be in 1..3");
    end

    arb_state_t       state;
    logic [1:0]       rr_ptr;
    logic [1:0]       gidx;
    logic [CNT_W-1:0] cnt;
    logic [NREQ-1:0]  req_eff;
    logic             pick_valid;
    logic [1:0]       pick_idx;

`ifdef NRISC_ARB_LOCK_EN
    logic locked;
    assign req_eff = (locked && lock) ? (req & 3'b100) : req;
`else
    logic unused_lock;
    assign unused_lock = lock;
    assign req_eff     = req;
`endif

    nrisc_rr_pick u_pick (
        .req       (req_eff),
        .rr_ptr    (rr_ptr),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= REQ_EXT;
            gidx      <= REQ_FETCH;
            cnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef NRISC_ARB_LOCK_EN
            locked    <= 1'b0;
`endif
        end else begin
            ack    <= '0;
            mem_en <= 1'b0;
            case (state)
                IDLE: begin
`ifdef NRISC_ARB_LOCK_EN
                    locked <= lock && (locked || (pick_valid && pick_idx == REQ_EXT));
`endif
                    if (pick_valid) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        rr_ptr    <= pick_idx;
                        gidx      <= pick_idx;
                        mem_en    <= 1'b1;
                        mem_we    <= we[pick_idx];
                        mem_addr  <= addr[int'(pick_idx)*TAM +: TAM];
                        mem_wdata <= wdata[int'(pick_idx)*TAM +: TAM];
                    end
                end
                ISSUE: begin
                    if (mem_we) begin
                        state     <= RESP;
                        ack[gidx] <= 1'b1;
                        mem_we    <= 1'b0;
                    end else begin
                        // Reads spend MEM_LAT cycles in WAIT so capture lines up with valid mem_rdata.
                        state <= WAIT;
                        cnt   <= CNT_W'(MEM_LAT - 1);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        ack[gidx] <= 1'b1;
                        rdata     <= mem_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
